mcu_bus_ctrl: RTL and testbench

Memory bus controller that sits directly downstream of the CPU's MCU port. It decodes each CPU address into a Game Boy memory region and serves HRAM (FF80–FFFE), IE (FFFF) and the DMA register (FF46) internally. All other regions are forwarded to a single external system bus. It also contains the OAM DMA engine, which copies 160 bytes into FE00–FE9F and blocks non-HRAM CPU accesses while it runs.

---
 rtl/mcu_bus_ctrl_pkg.sv | 83 ++++++++
 rtl/mcu_oam_dma.sv | 92 +++++++++
 rtl/mcu_bus_ctrl.sv | 114 +++++++++++
 tb/tb_mcu_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_bus_ctrl_pkg.sv
// Shared definitions for the MCU bus controller: region codes, address map,
// DMA state encoding and the CPU address decoder.
package mcu_bus_ctrl_pkg;

  localparam logic [2:0] REGION_ROM  = 3'd0;
  localparam logic [2:0] REGION_VRAM = 3'd1;
  localparam logic [2:0] REGION_ERAM = 3'd2;
  localparam logic [2:0] REGION_WRAM = 3'd3;
  localparam logic [2:0] REGION_OAM  = 3'd4;
  localparam logic [2:0] REGION_IO   = 3'd5;
  localparam logic [2:0] REGION_NONE = 3'd7;

  localparam logic [15:0] ROM_END       = 16'h7FFF;
  localparam logic [15:0] VRAM_BASE     = 16'h8000;
  localparam logic [15:0] ERAM_BASE     = 16'hA000;
  localparam logic [15:0] WRAM_BASE     = 16'hC000;
  localparam logic [15:0] ECHO_BASE     = 16'hE000;
  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam logic [15:0] UNUSABLE_BASE = 16'hFEA0;
  localparam logic [15:0] IO_BASE       = 16'hFF00;
  localparam logic [15:0] HRAM_BASE     = 16'hFF80;
  localparam logic [15:0] REG_DMA       = 16'hFF46;
  localparam logic [15:0] REG_IE        = 16'hFFFF;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_RD,
    DMA_WR
  } dmaState_e;

  typedef enum logic [1:0] {
    BUS_CPU,
    BUS_HOLD,
    BUS_DMA_RD,
    BUS_DMA_WR
  } busSel_e;

  typedef enum logic [3:0] {
    TGT_ROM,
    TGT_VRAM,
    TGT_ERAM,
    TGT_WRAM,
    TGT_ECHO,
    TGT_OAM,
    TGT_UNUSABLE,
    TGT_IO,
    TGT_DMA,
    TGT_HRAM,
    TGT_IE
  } target_e;

  function automatic target_e decodeTarget(input logic [15:0] addr);
    target_e t;
    if (addr <= ROM_END)            t = TGT_ROM;
    else if (addr < ERAM_BASE)      t = TGT_VRAM;
    else if (addr < WRAM_BASE)      t = TGT_ERAM;
    else if (addr < ECHO_BASE)      t = TGT_WRAM;
    else if (addr < OAM_BASE)       t = TGT_ECHO;
    else if (addr < UNUSABLE_BASE)  t = TGT_OAM;
    else if (addr < IO_BASE)        t = TGT_UNUSABLE;
    else if (addr == REG_DMA)       t = TGT_DMA;
    else if (addr < HRAM_BASE)      t = TGT_IO;
    else if (addr == REG_IE)        t = TGT_IE;
    else                            t = TGT_HRAM;
    return t;
  endfunction

  function automatic logic [2:0] targetRegion(input target_e t);
    logic [2:0] r;
    case (t)
      TGT_ROM:              r = REGION_ROM;
      TGT_VRAM:             r = REGION_VRAM;
      TGT_ERAM:             r = REGION_ERAM;
      TGT_WRAM, TGT_ECHO:   r = REGION_WRAM;
      TGT_OAM:              r = REGION_OAM;
      TGT_IO:               r = REGION_IO;
      default:              r = REGION_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcu_oam_dma.sv
// OAM DMA engine: alternating read/write of DMA_LEN bytes into FE00.. from a
// page selected by the FF46 write.
//   state     | meaning
//   DMA_IDLE  | no transfer, CPU owns the bus
//   DMA_START | one dead cycle after the FF46 write
//   DMA_RD    | read source byte {src, idx}
//   DMA_WR    | write captured byte to FE00 + idx
module mcu_oam_dma
  import mcu_bus_ctrl_pkg::*;
#(
  parameter int DMA_LEN = 160
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [7:0]  iSrc,
  input  logic [7:0]  iBusData,
  output busSel_e     oBusSel,
  output logic [15:0] oDmaAddr,
  output logic [7:0]  oDmaData,
  output logic [7:0]  oSrcReg,
  output logic        oActive
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dmaState_e  state, stateNext;
  logic [7:0] idx, idxNext;
  logic [7:0] srcReg, srcEff, captureReg;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state      <= DMA_IDLE;
      idx        <= 8'h00;
      srcReg     <= 8'h00;
      captureReg <= 8'h00;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      if (iStart) srcReg <= iSrc;
      if (state == DMA_RD) captureReg <= iBusData;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    unique case (state)
      DMA_IDLE:  stateNext = DMA_IDLE;
      DMA_START: stateNext = DMA_RD;
      DMA_RD:    stateNext = DMA_WR;
      DMA_WR: begin
        if (idx == LAST_IDX) begin
          stateNext = DMA_IDLE;
          idxNext   = 8'h00;
        end else begin
          stateNext = DMA_RD;
          idxNext   = idx + 8'h01;
        end
      end
      default: stateNext = DMA_IDLE;
    endcase
    // A new FF46 write always wins, including in the final WR cycle.
    if (iStart) begin
      stateNext = DMA_START;
      idxNext   = 8'h00;
    end
  end

  // Sources E0..FF alias down to C0..DF (echo of WRAM).
  assign srcEff = (srcReg >= 8'hE0) ? (srcReg & 8'hDF) : srcReg;

  always_comb begin
    oBusSel  = BUS_CPU;
    oDmaAddr = {srcEff, idx};
    unique case (state)
      DMA_IDLE:  oBusSel = BUS_CPU;
      DMA_START: oBusSel = BUS_HOLD;
      DMA_RD:    oBusSel = BUS_DMA_RD;
      DMA_WR: begin
        oBusSel  = BUS_DMA_WR;
        oDmaAddr = OAM_BASE + {8'h00, idx};
      end
      default:   oBusSel = BUS_CPU;
    endcase
  end

  assign oDmaData = captureReg;
  assign oSrcReg  = srcReg;
  assign oActive  = (state != DMA_IDLE);

endmodule

// File: rtl/mcu_bus_ctrl.sv
// CPU-side memory bus controller: region decode, internal HRAM/IE/FF46,
// external bus forwarding and arbitration against the OAM DMA engine.
module mcu_bus_ctrl
  import mcu_bus_ctrl_pkg::*;
#(
  parameter int DMA_LEN    = 160,
  parameter int HRAM_DEPTH = 127
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  input  logic        iCpuReadRequest,
  output logic [7:0]  oCpuData,
  output logic [15:0] oBusAddr,
  output logic [7:0]  oBusData,
  output logic        oBusWe,
  output logic        oBusRe,
  input  logic [7:0]  iBusData,
  output logic [2:0]  oRegion,
  output logic        oDmaActive
);

  target_e     cpuTarget;
  logic        cpuExternal, cpuHighRam, dmaStart, dmaActive;
  busSel_e     busSel;
  logic [15:0] dmaAddr;
  logic [7:0]  dmaData, dmaReg, ieReg, readMux;
  logic [6:0]  hramIdx;
  logic [7:0]  hram [HRAM_DEPTH];

  assign cpuTarget  = decodeTarget(iCpuAddr);
  assign cpuExternal = !(cpuTarget inside {TGT_UNUSABLE, TGT_DMA, TGT_HRAM, TGT_IE});
  assign cpuHighRam = (cpuTarget == TGT_HRAM) || (cpuTarget == TGT_IE);
  assign dmaStart   = iCpuWe && (cpuTarget == TGT_DMA);
  assign hramIdx    = iCpuAddr[6:0];

  mcu_oam_dma #(
    .DMA_LEN (DMA_LEN)
  ) uDma (
    .iClock   (iClock),
    .iReset   (iReset),
    .iStart   (dmaStart),
    .iSrc     (iCpuData),
    .iBusData (iBusData),
    .oBusSel  (busSel),
    .oDmaAddr (dmaAddr),
    .oDmaData (dmaData),
    .oSrcReg  (dmaReg),
    .oActive  (dmaActive)
  );

  assign oDmaActive = dmaActive;

  always_comb begin
    oBusAddr = (cpuTarget == TGT_ECHO) ? (iCpuAddr & ~16'h2000) : iCpuAddr;
    oBusData = iCpuData;
    oBusWe   = 1'b0;
    oBusRe   = 1'b0;
    oRegion  = REGION_NONE;
    unique case (busSel)
      BUS_CPU: begin
        if (cpuExternal) begin
          oRegion = targetRegion(cpuTarget);
          oBusWe  = iCpuWe;
          oBusRe  = iCpuReadRequest & ~iCpuWe;
        end
      end
      BUS_HOLD: oRegion = REGION_NONE;
      BUS_DMA_RD: begin
        oBusAddr = dmaAddr;
        oBusRe   = 1'b1;
        oRegion  = targetRegion(decodeTarget(dmaAddr));
      end
      BUS_DMA_WR: begin
        oBusAddr = dmaAddr;
        oBusData = dmaData;
        oBusWe   = 1'b1;
        oRegion  = REGION_OAM;
      end
      default: oRegion = REGION_NONE;
    endcase
  end

  // While DMA owns the bus only HRAM and IE are visible to the CPU.
  always_comb begin
    readMux = 8'hFF;
    if (!dmaActive || cpuHighRam) begin
      unique case (cpuTarget)
        TGT_HRAM:     readMux = hram[hramIdx];
        TGT_IE:       readMux = ieReg;
        TGT_DMA:      readMux = dmaReg;
        TGT_UNUSABLE: readMux = 8'hFF;
        default:      readMux = iBusData;
      endcase
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oCpuData <= 8'h00;
      ieReg    <= 8'h00;
    end else begin
      oCpuData <= readMux;
      if (iCpuWe && cpuTarget == TGT_IE) ieReg <= iCpuData;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iReset && iCpuWe && cpuTarget == TGT_HRAM) hram[hramIdx] <= iCpuData;
  end

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// Self-checking bench for mcu_bus_ctrl: directed steps plus random CPU traffic
// against a cycle-count reference model of the memory map and OAM DMA.
module tb_mcu_bus_ctrl;
  import mcu_bus_ctrl_pkg::*;

  localparam int DMA_LEN = 160;
  localparam int DMA_CYCLES = 1 + 2 * DMA_LEN;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [15:0] iCpuAddr = 16'h0000;
  logic [7:0]  iCpuData = 8'h00;
  logic        iCpuWe = 1'b0;
  logic        iCpuReadRequest = 1'b0;
  logic [7:0]  iBusData = 8'h00;
  logic [7:0]  oCpuData, oBusData;
  logic [15:0] oBusAddr;
  logic        oBusWe, oBusRe, oDmaActive;
  logic [2:0]  oRegion;

  mcu_bus_ctrl #(.DMA_LEN(DMA_LEN), .HRAM_DEPTH(127)) dut (
    .iClock          (iClock),
    .iReset          (iReset),
    .iCpuAddr        (iCpuAddr),
    .iCpuData        (iCpuData),
    .iCpuWe          (iCpuWe),
    .iCpuReadRequest (iCpuReadRequest),
    .oCpuData        (oCpuData),
    .oBusAddr        (oBusAddr),
    .oBusData        (oBusData),
    .oBusWe          (oBusWe),
    .oBusRe          (oBusRe),
    .iBusData        (iBusData),
    .oRegion         (oRegion),
    .oDmaActive      (oDmaActive)
  );

  always #5 iClock = ~iClock;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] hramM [127];
  bit         hramV [127];
  logic [7:0] ieM = 8'h00;
  logic [7:0] ff46M = 8'h00;
  bit         dmaOn = 1'b0;
  int         dmaPhase = 0;
  logic [7:0] dmaByte = 8'h00;
  int         activeCount = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] expRegion(input logic [15:0] a);
    if (a < 16'h8000) return REGION_ROM;
    if (a < 16'hA000) return REGION_VRAM;
    if (a < 16'hC000) return REGION_ERAM;
    if (a < 16'hFE00) return REGION_WRAM;
    if (a < 16'hFEA0) return REGION_OAM;
    if (a >= 16'hFF00 && a < 16'hFF80 && a != 16'hFF46) return REGION_IO;
    return REGION_NONE;
  endfunction

  function automatic bit isInternal(input logic [15:0] a);
    return (a >= 16'hFEA0 && a <= 16'hFEFF) || a == 16'hFF46 || a >= 16'hFF80;
  endfunction

  function automatic logic [7:0] effSrc(input logic [7:0] s);
    return (s >= 8'hE0) ? s - 8'h20 : s;
  endfunction

  // One CPU cycle: drive at posedge+1, check bus at negedge, check read data after the edge.
  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input bit we, input bit rd,
                     input logic [7:0] bd);
    logic [7:0]  expRd;
    bit          expRdValid;
    int          j;
    logic [15:0] ea;
    iCpuAddr = a; iCpuData = d; iCpuWe = we; iCpuReadRequest = rd; iBusData = bd;
    #4;
    check("dmaActive", 32'(oDmaActive), 32'(dmaOn));
    if (oDmaActive === 1'b1) activeCount++;
    if (dmaOn) begin
      if (dmaPhase == 0) begin
        check("startWe", 32'(oBusWe), 32'd0);
        check("startRe", 32'(oBusRe), 32'd0);
      end else begin
        j = (dmaPhase - 1) / 2;
        if ((dmaPhase - 1) % 2 == 0) begin
          ea = {effSrc(ff46M), 8'(j)};
          check("dmaRdAddr", 32'(oBusAddr), 32'(ea));
          check("dmaRdRe", 32'(oBusRe), 32'd1);
          check("dmaRdWe", 32'(oBusWe), 32'd0);
          check("dmaRdRegion", 32'(oRegion), 32'(expRegion(ea)));
        end else begin
          check("dmaWrAddr", 32'(oBusAddr), 32'(16'hFE00 + 16'(j)));
          check("dmaWrData", 32'(oBusData), 32'(dmaByte));
          check("dmaWrWe", 32'(oBusWe), 32'd1);
          check("dmaWrRe", 32'(oBusRe), 32'd0);
          check("dmaWrRegion", 32'(oRegion), 32'(REGION_OAM));
        end
      end
    end else if (isInternal(a)) begin
      check("intWe", 32'(oBusWe), 32'd0);
      check("intRe", 32'(oBusRe), 32'd0);
      check("intRegion", 32'(oRegion), 32'(REGION_NONE));
    end else begin
      ea = (a >= 16'hE000 && a <= 16'hFDFF) ? a - 16'h2000 : a;
      check("extAddr", 32'(oBusAddr), 32'(ea));
      check("extRegion", 32'(oRegion), 32'(expRegion(a)));
      check("extWe", 32'(oBusWe), 32'(we));
      check("extRe", 32'(oBusRe), 32'(rd && !we));
      if (we) check("extData", 32'(oBusData), 32'(d));
    end
    expRdValid = 1'b1;
    if (a >= 16'hFF80 && a <= 16'hFFFE) begin
      expRd = hramM[a - 16'hFF80];
      expRdValid = hramV[a - 16'hFF80];
    end else if (a == 16'hFFFF) expRd = ieM;
    else if (dmaOn) expRd = 8'hFF;
    else if (a == 16'hFF46) expRd = ff46M;
    else if (a >= 16'hFEA0 && a <= 16'hFEFF) expRd = 8'hFF;
    else expRd = bd;
    @(posedge iClock);
    if (dmaOn && dmaPhase > 0 && (dmaPhase - 1) % 2 == 0) dmaByte = bd;
    if (dmaOn) begin
      dmaPhase++;
      if (dmaPhase == DMA_CYCLES) dmaOn = 1'b0;
    end
    if (we) begin
      if (a >= 16'hFF80 && a <= 16'hFFFE) begin
        hramM[a - 16'hFF80] = d;
        hramV[a - 16'hFF80] = 1'b1;
      end
      if (a == 16'hFFFF) ieM = d;
      if (a == 16'hFF46) begin
        ff46M = d; dmaOn = 1'b1; dmaPhase = 0;
      end
    end
    #1;
    if (expRdValid) check("cpuRead", 32'(oCpuData), 32'(expRd));
  endtask

  task automatic idleCyc();
    cyc(16'h0000, 8'h00, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic randCyc();
    logic [15:0] a;
    bit          we;
    case ($urandom_range(0, 5))
      0: a = 16'($urandom);
      1: a = 16'($urandom_range(16'hFF80, 16'hFFFE));
      2: a = 16'($urandom_range(16'hE000, 16'hFDFF));
      3: a = 16'($urandom_range(16'hFE00, 16'hFEFF));
      4: a = 16'hFFFF;
      default: a = 16'($urandom_range(16'hFF00, 16'hFF7F));
    endcase
    we = 1'($urandom_range(0, 1));
    if (a == 16'hFF46) we = 1'b0;
    cyc(a, 8'($urandom), we, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic doReset();
    iReset = 1'b1; iCpuWe = 1'b0; iCpuReadRequest = 1'b0; iCpuAddr = 16'h0000;
    @(posedge iClock);
    #1;
    dmaOn = 1'b0; dmaPhase = 0; ieM = 8'h00; ff46M = 8'h00;
    check("rstActive", 32'(oDmaActive), 32'd0);
    check("rstWe", 32'(oBusWe), 32'd0);
    check("rstRe", 32'(oBusRe), 32'd0);
    check("rstCpuData", 32'(oCpuData), 32'd0);
    iReset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 127; i++) hramV[i] = 1'b0;
    doReset();

    // Reset values and first HRAM access
    cyc(16'hFF46, 8'h00, 1'b0, 1'b1, 8'h77);
    cyc(16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h77);
    cyc(16'hFF80, 8'h5A, 1'b1, 1'b0, 8'h77);
    cyc(16'hFF80, 8'h00, 1'b0, 1'b1, 8'h77);

    // Echo region and unusable region
    cyc(16'hE123, 8'h00, 1'b0, 1'b1, 8'h3C);
    cyc(16'hFEB0, 8'h00, 1'b0, 1'b1, 8'h3C);
    cyc(16'hFEB0, 8'h99, 1'b1, 1'b0, 8'h3C);
    cyc(16'hFFFF, 8'hA5, 1'b1, 1'b0, 8'h00);
    cyc(16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 127; i++) cyc(16'hFF80 + 16'(i), 8'($urandom), 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 200; i++) randCyc();

    // Full transfer from C1 with CPU traffic mixed in
    cyc(16'hFF46, 8'hC1, 1'b1, 1'b0, 8'h00);
    activeCount = 0;
    for (int i = 0; i < DMA_CYCLES + 8; i++) begin
      if (i == 10)      cyc(16'h0150, 8'h00, 1'b0, 1'b1, 8'h12);
      else if (i == 20) cyc(16'hFF90, 8'hAB, 1'b1, 1'b0, 8'h34);
      else if (i == 21) cyc(16'hFF90, 8'h00, 1'b0, 1'b1, 8'h56);
      else if (i == 30) cyc(16'h0150, 8'h44, 1'b1, 1'b0, 8'h78);
      else randCyc();
    end
    check("activeLenC1", 32'(activeCount), 32'(DMA_CYCLES));

    // Restart after 50 cycles with a new source
    cyc(16'hFF46, 8'hC1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 49; i++) idleCyc();
    cyc(16'hFF46, 8'h80, 1'b1, 1'b0, 8'h00);
    activeCount = 0;
    for (int i = 0; i < DMA_CYCLES + 5; i++) randCyc();
    check("activeLenRestart", 32'(activeCount), 32'(DMA_CYCLES));

    // Restart landing exactly on the final WR cycle
    cyc(16'hFF46, 8'h40, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 400 && !(dmaOn && dmaPhase == DMA_CYCLES - 1); k++) idleCyc();
    check("reachFinalWr", 32'(dmaPhase), 32'(DMA_CYCLES - 1));
    cyc(16'hFF46, 8'h55, 1'b1, 1'b0, 8'h00);
    activeCount = 0;
    for (int i = 0; i < DMA_CYCLES + 3; i++) idleCyc();
    check("activeLenFinalWr", 32'(activeCount), 32'(DMA_CYCLES));

    // Echo-aliased source, reset in active cycle 100
    cyc(16'hFF46, 8'hF0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 99; i++) idleCyc();
    doReset();
    for (int i = 0; i < 4; i++) randCyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
